// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch (read-only) port
// and the data (read/write) port, with a registered req/ack bus and an access watchdog.
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  // instruction port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  output logic              i_err,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              d_err,
  // memory bus
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  // status
  output logic              busy,
  output logic              grant_d
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e          state_q;
  logic            last_grant_d_q;
  logic [CntW-1:0] cnt_q;
  logic            pick_d;

  // On contention the port that did not win last time gets the bus.
  always_comb begin
    pick_d = d_req & (~i_req | ~last_grant_d_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      last_grant_d_q <= 1'b0;
      cnt_q          <= '0;
      m_req          <= 1'b0;
      m_we           <= 1'b0;
      m_addr         <= '0;
      m_wdata        <= '0;
      m_wstrb        <= '0;
      i_rdata        <= '0;
      i_ack          <= 1'b0;
      i_err          <= 1'b0;
      d_rdata        <= '0;
      d_ack          <= 1'b0;
      d_err          <= 1'b0;
      busy           <= 1'b0;
      grant_d        <= 1'b0;
    end else begin
      // Acks and error flags are single-cycle pulses.
      i_ack <= 1'b0;
      i_err <= 1'b0;
      d_ack <= 1'b0;
      d_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_req || d_req) begin
            if (pick_d) begin
              m_we    <= d_we;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              m_wstrb <= d_wstrb;
            end else begin
              m_we    <= 1'b0;
              m_addr  <= i_addr;
              m_wdata <= '0;
              m_wstrb <= '0;
            end
            m_req          <= 1'b1;
            grant_d        <= pick_d;
            last_grant_d_q <= pick_d;
            cnt_q          <= '0;
            busy           <= 1'b1;
            state_q        <= StBusy;
          end
        end
        StBusy: begin
          if (m_ack) begin
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            state_q <= StResp;
            if (grant_d) begin
              d_ack <= 1'b1;
              if (!m_we) d_rdata <= m_rdata;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= m_rdata;
            end
          end else if (cnt_q == CntMax) begin
            // Watchdog abort: complete the access with an error and zeroed read data.
            m_req   <= 1'b0;
            state_q <= StResp;
            if (grant_d) begin
              d_ack <= 1'b1;
              d_err <= 1'b1;
              if (!m_we) d_rdata <= '0;
            end else begin
              i_ack   <= 1'b1;
              i_err   <= 1'b1;
              i_rdata <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StResp: begin
          // Requests are ignored here so a request held through its ack is not served twice.
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          m_req   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
